// File: rtl/alu_sweep_ctrl.sv
// Drives an opcode sweep into an external ALU, holds operands for SETTLE cycles, captures y and hands each result to a consumer.
// Latency: SETTLE+1 cycles per result; backpressure: res_valid/res_data/res_op hold in WAIT until res_ready.
module alu_sweep_ctrl #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] a_in,
   input  logic [3:0] b_in,
   input  logic [3:0] op_first,
   input  logic [3:0] op_last,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [3:0] s,
   input  logic [7:0] y,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [3:0] res_op,
   output logic [4:0] res_count,
   output logic [7:0] checksum,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   logic [1:0] state_q, state_d;
   logic [3:0] a_q, a_d, b_q, b_d, s_q, s_d, last_q, last_d;
   logic [3:0] cnt_q, cnt_d;
   logic       res_valid_q, res_valid_d;
   logic [7:0] res_data_q, res_data_d;
   logic [3:0] res_op_q, res_op_d;
   logic [4:0] res_count_q, res_count_d;
   logic [7:0] checksum_q, checksum_d;
   logic       done_q, done_d;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      res_count_d = res_count_q;
      checksum_d  = checksum_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // abort beats start when both arrive in IDLE
            if (start && !abort) begin
               a_d         = a_in;
               b_d         = b_in;
               s_d         = op_first;
               last_d      = op_last;
               cnt_d       = SETTLE_C;
               res_count_d = 5'd0;
               checksum_d  = 8'd0;
               state_d     = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd1) begin
               res_data_d  = y;
               res_op_d    = s_q;
               res_valid_d = 1'b1;
               state_d     = ST_WAIT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WAIT: begin
            // an abort discards a result handshaking on the same edge
            if (abort) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (res_ready) begin
               res_valid_d = 1'b0;
               checksum_d  = checksum_q + res_data_q;
               res_count_d = res_count_q + 5'd1;
               if (s_q == last_q) begin
                  state_d = ST_DONE;
               end else begin
                  s_d     = s_q + 4'd1;
                  cnt_d   = SETTLE_C;
                  state_d = ST_DRIVE;
               end
            end
         end
         default: begin
            done_d  = !abort;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= 4'd0;
         b_q         <= 4'd0;
         s_q         <= 4'd0;
         last_q      <= 4'd0;
         cnt_q       <= 4'd0;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'd0;
         res_op_q    <= 4'd0;
         res_count_q <= 5'd0;
         checksum_q  <= 8'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
         res_count_q <= res_count_d;
         checksum_q  <= checksum_d;
         done_q      <= done_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign s         = s_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign res_count = res_count_q;
   assign checksum  = checksum_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Scoreboard bench for alu_sweep_ctrl with a behavioural ALU closing the a/b/s -> y loop.
module tb_alu_sweep_ctrl;

   localparam int SETTLE = 1;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, res_ready;
   logic [3:0] a_in, b_in, op_first, op_last;
   logic [3:0] a, b, s, res_op;
   logic [7:0] y, res_data, checksum;
   logic       res_valid, busy, done;
   logic [4:0] res_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [11:0] sb_q[$];
   logic [7:0]  obs_sum = 8'd0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [3:0] fa, input logic [3:0] fb, input logic [3:0] fs);
      return ((8'(fa) * 8'(fb)) + {fs, fs ^ fa}) ^ {fb, fs};
   endfunction

   assign y = alu_f(a, b, s);

   alu_sweep_ctrl #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a_in(a_in), .b_in(b_in), .op_first(op_first), .op_last(op_last),
      .a(a), .b(b), .s(s), .y(y),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op), .res_count(res_count),
      .checksum(checksum), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // results that handshake on a non-aborted, non-reset edge are checked in order
   always @(negedge clk) begin
      if (rst_n && !abort && res_valid && res_ready) begin
         logic [11:0] e;
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("res_op", 32'(res_op), 32'(e[11:8]));
            chk("res_data", 32'(res_data), 32'(e[7:0]));
         end
         obs_sum = obs_sum + res_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sweep(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tf,
                              input logic [3:0] tl, output int n, output logic [7:0] esum);
      logic [3:0] d, op;
      d    = tl - tf;
      n    = int'(d) + 1;
      esum = 8'd0;
      for (int k = 0; k < n; k++) begin
         op   = tf + 4'(k);
         sb_q.push_back({op, alu_f(ta, tb, op)});
         esum = esum + alu_f(ta, tb, op);
      end
      a_in = ta; b_in = tb; op_first = tf; op_last = tl;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int n, input int exp_cyc,
                            input logic [7:0] esum, input logic [7:0] obs_base);
      int cyc, busy_cnt;
      logic seen;
      cyc = 0; busy_cnt = int'(busy); seen = 1'b0;
      while (cyc < 2000 && !seen) begin
         step();
         cyc++;
         if (done) seen = 1'b1;
         else busy_cnt += int'(busy);
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (exp_cyc >= 0) begin
         chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
         chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc));
      end
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_count"}, 32'(res_count), 32'(n));
      chk({tag, "_checksum"}, 32'(checksum), 32'(esum));
      chk({tag, "_checksum_obs"}, 32'(checksum), 32'(8'(obs_sum - obs_base)));
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
      step();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int n, seen;
      logic [7:0] esum, base, d0, ex;
      logic [3:0] o0;
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; res_ready = 1'b1;
      a_in = 4'hF; b_in = 4'hF; op_first = 4'h3; op_last = 4'h9;
      step(); step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", 32'({a, b, s, res_op}), 32'd0);
      chk("rst_res", 32'({res_valid, res_data, res_count, checksum, done}), 32'd0);

      // full sweep; start already high on the first edge out of reset
      rst_n = 1'b1;
      base = obs_sum;
      start_sweep(4'b1010, 4'b1001, 4'h0, 4'hF, n, esum);
      wait_done("full", n, n * (SETTLE + 1) + 1, esum, base);

      // abort at the third WAIT cycle
      start_sweep(4'h3, 4'hC, 4'h0, 4'hF, n, esum);
      seen = 0;
      for (int i = 0; i < 200 && seen < 3; i++) begin
         if (res_valid) begin
            seen++;
            if (seen == 3) abort = 1'b1;
         end
         if (seen < 3) step();
      end
      chk("abort_reached", 32'(seen), 32'd3);
      step();
      abort = 1'b0;
      sb_q.delete();
      ex = alu_f(4'h3, 4'hC, 4'h0) + alu_f(4'h3, 4'hC, 4'h1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(res_valid), 32'd0);
      chk("abort_count", 32'(res_count), 32'd2);
      chk("abort_checksum", 32'(checksum), 32'(ex));
      step();
      chk("abort_no_done", 32'(done), 32'd0);

      // abort and start together in IDLE
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      chk("abort_start_idle", 32'(busy), 32'd0);
      chk("abort_start_count", 32'(res_count), 32'd2);

      base = obs_sum;
      start_sweep(4'h6, 4'h5, 4'hE, 4'h1, n, esum);
      chk("wrap_len", 32'(n), 32'd4);
      wait_done("wrap", n, n * (SETTLE + 1) + 1, esum, base);

      base = obs_sum;
      start_sweep(4'h2, 4'hB, 4'h5, 4'h5, n, esum);
      wait_done("single", n, 3, esum, base);

      // backpressure: hold res_ready low for 5 WAIT cycles
      res_ready = 1'b0;
      base = obs_sum;
      start_sweep(4'h9, 4'h4, 4'h7, 4'h8, n, esum);
      for (int i = 0; i < 50 && !res_valid; i++) step();
      d0 = res_data; o0 = res_op;
      chk("bp_first_data", 32'(d0), 32'(alu_f(4'h9, 4'h4, 4'h7)));
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_stable", 32'({res_op, res_data}), 32'({o0, d0}));
         chk("bp_count", 32'(res_count), 32'd0);
         step();
      end
      res_ready = 1'b1;
      step();
      chk("bp_count_after", 32'(res_count), 32'd1);
      wait_done("bp", n, -1, esum, base);

      // reset mid-sweep while a result is pending
      start_sweep(4'h5, 4'h7, 4'h0, 4'hF, n, esum);
      seen = 0;
      for (int i = 0; i < 200 && seen < 2; i++) begin
         if (res_valid) seen++;
         if (seen < 2) step();
      end
      chk("rst_mid_reached", 32'(seen), 32'd2);
      rst_n = 1'b0; start = 1'b1;
      step();
      chk("rst_mid_ops", 32'({a, b, s, res_op}), 32'd0);
      chk("rst_mid_res", 32'({res_valid, res_data, res_count, checksum}), 32'd0);
      chk("rst_mid_ctl", 32'({busy, done}), 32'd0);
      rst_n = 1'b1; start = 1'b0;
      sb_q.delete();
      step();
      chk("rst_mid_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
